// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: handshaked instruction intake, register-file decode, ALU/data-memory control, writeback.
// Optional build macro CU_ZERO_REG_EN: register 0 is hard-wired to zero.
module cu_multicycle #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  localparam int REG_BITS    = $clog2(NUM_REGS),
  localparam int INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INSTR_WIDTH-1:0]         instr,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [DATA_WIDTH-1:0]          result2,
  input  logic                           mem_ack,
  output logic [DATA_WIDTH-1:0]          operand1,
  output logic [DATA_WIDTH-1:0]          operand2,
  output logic [DATA_WIDTH-1:0]          offset,
  output logic [3:0]                     opcode,
  output logic                           sel1,
  output logic                           sel3,
  output logic                           w_r,
  output logic                           mem_req,
  output logic                           done,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int OP_LSB   = 0;
  localparam int OFF_LSB  = OP_LSB + 4;
  localparam int RS2_LSB  = OFF_LSB + DATA_WIDTH;
  localparam int RS1_LSB  = RS2_LSB + REG_BITS;
  localparam int RD_LSB   = RS1_LSB + REG_BITS;
  localparam int TYPE_LSB = RD_LSB + REG_BITS;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    T_NOP   = 2'b00,
    T_ALU   = 2'b01,
    T_LOAD  = 2'b10,
    T_STORE = 2'b11
  } itype_t;

  state_t state_q, state_d;
  logic   done_c;

  itype_t                in_type;
  logic [REG_BITS-1:0]   in_rd, in_rs1, in_rs2;
  logic [DATA_WIDTH-1:0] in_offset;
  logic [3:0]            in_opcode;

  itype_t              ir_type;
  logic [REG_BITS-1:0] ir_rd;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  accept;
  logic                  wb_en;

  assign in_type   = itype_t'(instr[TYPE_LSB +: 2]);
  assign in_rd     = instr[RD_LSB +: REG_BITS];
  assign in_rs1    = instr[RS1_LSB +: REG_BITS];
  assign in_rs2    = instr[RS2_LSB +: REG_BITS];
  assign in_offset = instr[OFF_LSB +: DATA_WIDTH];
  assign in_opcode = instr[OP_LSB +: 4];

  function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [REG_BITS-1:0] idx);
`ifdef CU_ZERO_REG_EN
    if (idx == '0) return '0;
`endif
    return regs[idx];
  endfunction

  assign instr_ready = (state_q == FETCH);
  // NOPs complete the handshake but never leave FETCH or touch the datapath outputs.
  assign accept      = instr_ready && instr_valid && (in_type != T_NOP);

  // Control: state register and next-state decode
  always_ff @(posedge clk) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      FETCH:     if (accept) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = (ir_type == T_ALU) ? WRITEBACK : MEM;
      MEM: begin
        if (mem_ack) begin
          if (ir_type == T_STORE) begin
            state_d = FETCH;
            done_c  = 1'b1;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        state_d = FETCH;
        done_c  = 1'b1;
      end
      default:   state_d = FETCH;
    endcase
  end

  // An instruction abandoned by reset must not report completion.
  assign done = done_c & rst;

  // Decode: latch instruction fields and register operands at acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_type  <= T_NOP;
      ir_rd    <= '0;
      operand1 <= '0;
      operand2 <= '0;
      offset   <= '0;
      opcode   <= 4'b1111;
      sel1     <= 1'b0;
      sel3     <= 1'b0;
      mem_req  <= 1'b0;
      w_r      <= 1'b0;
    end else begin
      if (accept) begin
        ir_type  <= in_type;
        ir_rd    <= in_rd;
        operand1 <= rf_read(in_rs1);
        operand2 <= (in_type == T_ALU) ? rf_read(in_rs2) : rf_read(in_rd);
        offset   <= in_offset;
        opcode   <= in_opcode;
        sel1     <= (in_type == T_ALU);
        sel3     <= (in_type != T_ALU);
      end
      // Registered from the next state so both strobes are high for the whole MEM residency.
      mem_req <= (state_d == MEM);
      w_r     <= (state_d == MEM) && (ir_type == T_STORE);
    end
  end

`ifdef CU_ZERO_REG_EN
  assign wb_en = (state_q == WRITEBACK) && (ir_rd != '0);
`else
  assign wb_en = (state_q == WRITEBACK);
`endif

  // Writeback: register file, reinitialised to its index on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_WIDTH'(i);
    end else if (wb_en) begin
      regs[ir_rd] <= result2;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = rf_read(REG_BITS'(g));
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle with a register-file scoreboard checked after each completion.
module tb_cu_multicycle;
  localparam int DW   = 8;
  localparam int NR   = 4;
  localparam int RB   = 2;
  localparam int IW   = 2 + 3*RB + DW + 4;
  localparam int NOPW = IW - 2;

  logic            clk, rst;
  logic [IW-1:0]   instr;
  logic            instr_valid, instr_ready;
  logic [DW-1:0]   result2;
  logic            mem_ack;
  logic [DW-1:0]   operand1, operand2, offset;
  logic [3:0]      opcode;
  logic            sel1, sel3, w_r, mem_req, done;
  logic [NR*DW-1:0] regs_flat;

  cu_multicycle #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .result2(result2), .mem_ack(mem_ack),
    .operand1(operand1), .operand2(operand2), .offset(offset), .opcode(opcode),
    .sel1(sel1), .sel3(sel3), .w_r(w_r), .mem_req(mem_req), .done(done),
    .regs_flat(regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [NR*DW-1:0] flat;
  } sb_t;

  sb_t           sb_q[$];
  logic [DW-1:0] m_regs [NR];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cnt_req = 0, cnt_wr = 0, cnt_done = 0;
  int            b_req, b_wr, b_done;
  logic [DW-1:0] e1, e2;

  always @(negedge clk) begin
    if (mem_req === 1'b1) cnt_req++;
    if (w_r === 1'b1)     cnt_wr++;
    if (done === 1'b1)    cnt_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = DW'(i);
  endtask

  task automatic model_write(input int rd, input logic [DW-1:0] v);
`ifdef CU_ZERO_REG_EN
    if (rd == 0) return;
`endif
    m_regs[rd] = v;
  endtask

  task automatic sb_push(input string tag);
    sb_t e;
    e.tag  = tag;
    e.flat = model_flat();
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed no pending entry expected one");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_flat"}, 64'(regs_flat), 64'(e.flat));
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [1:0] t, input logic [RB-1:0] rd,
                                       input logic [RB-1:0] rs1, input logic [RB-1:0] rs2,
                                       input logic [DW-1:0] off, input logic [3:0] op);
    return {t, rd, rs1, rs2, off, op};
  endfunction

  initial begin
    int lat;
    rst = 1'b0; instr = '0; instr_valid = 1'b0; result2 = '0; mem_ack = 1'b0;
    tick(); tick();
    model_reset();
    chk("rst_op1",   64'(operand1), 64'(0));
    chk("rst_op2",   64'(operand2), 64'(0));
    chk("rst_off",   64'(offset), 64'(0));
    chk("rst_opc",   64'(opcode), 64'hF);
    chk("rst_sel",   64'({sel1, sel3, w_r, mem_req, done}), 64'(0));
    chk("rst_ready", 64'(instr_ready), 64'(1));
    chk("rst_flat",  64'(regs_flat), 64'(model_flat()));
    rst = 1'b1;

    // ALU: rd=3 rs1=1 rs2=2 opcode=0010
    instr = mk(2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 4'b0010); instr_valid = 1'b1;
    e1 = m_regs[1]; e2 = m_regs[2];
    model_write(3, 8'h05); sb_push("alu");
    tick();
    instr_valid = 1'b0; instr = mk(2'b11, 2'd0, 2'd0, 2'd0, 8'hFF, 4'hA);
    chk("alu_op1",   64'(operand1), 64'(e1));
    chk("alu_op2",   64'(operand2), 64'(e2));
    chk("alu_sel",   64'({sel1, sel3}), 64'(2'b10));
    chk("alu_opc",   64'(opcode), 64'(4'b0010));
    chk("alu_ready_c1", 64'(instr_ready), 64'(0));
    chk("alu_done_c1",  64'(done), 64'(0));
    tick();
    chk("alu_done_c2", 64'(done), 64'(0));
    result2 = 8'h05;
    tick();
    chk("alu_done_c3", 64'(done), 64'(1));
    tick();
    chk("alu_ready_c4", 64'(instr_ready), 64'(1));
    chk("alu_done_c4",  64'(done), 64'(0));
    sb_pop();

    // LOAD: rd=0 rs1=2 offset=10, ack after 3 wait cycles; instr changes must be ignored
    instr = mk(2'b10, 2'd0, 2'd2, 2'd0, 8'h10, 4'h0); instr_valid = 1'b1;
    e1 = m_regs[2]; e2 = m_regs[0];
    model_write(0, 8'hA7); sb_push("load");
    b_req = cnt_req; b_wr = cnt_wr; b_done = cnt_done;
    tick();
    instr = mk(2'b01, 2'd1, 2'd3, 2'd3, 8'h55, 4'h7);
    chk("ld_op1", 64'(operand1), 64'(e1));
    chk("ld_op2", 64'(operand2), 64'(e2));
    chk("ld_sel", 64'({sel1, sel3}), 64'(2'b01));
    chk("ld_off", 64'(offset), 64'(8'h10));
    tick();
    chk("ld_req_c2", 64'(mem_req), 64'(0));
    tick();
    chk("ld_req_c3", 64'(mem_req), 64'(1));
    chk("ld_wr_c3",  64'(w_r), 64'(0));
    result2 = 8'hA7; instr = mk(2'b10, 2'd3, 2'd0, 2'd1, 8'h99, 4'h3);
    tick(); tick(); tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; instr_valid = 1'b0;
    chk("ld_done_wb", 64'(done), 64'(1));
    chk("ld_req_wb",  64'(mem_req), 64'(0));
    chk("ld_hold_op1", 64'(operand1), 64'(e1));
    chk("ld_hold_off", 64'(offset), 64'(8'h10));
    tick();
    chk("ld_ready", 64'(instr_ready), 64'(1));
    chk("ld_req_cycles",  64'(cnt_req - b_req), 64'(4));
    chk("ld_wr_cycles",   64'(cnt_wr - b_wr), 64'(0));
    chk("ld_done_cycles", 64'(cnt_done - b_done), 64'(1));
    sb_pop();

    // STORE: rd=1 rs1=3 offset=04, ack held high throughout
    instr = mk(2'b11, 2'd1, 2'd3, 2'd0, 8'h04, 4'h0); instr_valid = 1'b1; mem_ack = 1'b1;
    e1 = m_regs[3]; e2 = m_regs[1];
    sb_push("store");
    b_req = cnt_req; b_wr = cnt_wr; b_done = cnt_done;
    tick();
    instr_valid = 1'b0;
    chk("st_op1", 64'(operand1), 64'(e1));
    chk("st_op2", 64'(operand2), 64'(e2));
    chk("st_off", 64'(offset), 64'(8'h04));
    chk("st_sel", 64'({sel1, sel3}), 64'(2'b01));
    tick();
    chk("st_exe", 64'({mem_req, done}), 64'(0));
    tick();
    chk("st_mem", 64'({mem_req, w_r, done}), 64'(3'b111));
    tick();
    mem_ack = 1'b0;
    chk("st_after", 64'({mem_req, w_r, done}), 64'(0));
    chk("st_ready", 64'(instr_ready), 64'(1));
    chk("st_req_cycles",  64'(cnt_req - b_req), 64'(1));
    chk("st_wr_cycles",   64'(cnt_wr - b_wr), 64'(1));
    chk("st_done_cycles", 64'(cnt_done - b_done), 64'(1));
    sb_pop();

    // NOP stream
    b_done = cnt_done;
    for (int k = 0; k < 5; k++) begin
      instr = {2'b00, NOPW'($urandom)}; instr_valid = 1'b1;
      tick();
      chk("nop_ready", 64'(instr_ready), 64'(1));
      chk("nop_done",  64'(done), 64'(0));
    end
    instr_valid = 1'b0;
    chk("nop_opc",   64'(opcode), 64'(4'h0));
    chk("nop_op1",   64'(operand1), 64'(e1));
    chk("nop_dones", 64'(cnt_done - b_done), 64'(0));
    chk("nop_flat",  64'(regs_flat), 64'(model_flat()));

    // Reset during a LOAD memory wait
    instr = mk(2'b10, 2'd2, 2'd1, 2'd0, 8'h20, 4'h6); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    chk("rl_req_pre", 64'(mem_req), 64'(1));
    rst = 1'b0;
    tick();
    rst = 1'b1; model_reset();
    chk("rl_req",   64'({mem_req, w_r}), 64'(0));
    chk("rl_opc",   64'(opcode), 64'hF);
    chk("rl_op1",   64'(operand1), 64'(0));
    chk("rl_ready", 64'(instr_ready), 64'(1));
    chk("rl_flat",  64'(regs_flat), 64'(model_flat()));
    b_done = cnt_done;
    mem_ack = 1'b1; result2 = 8'hEE;
    tick(); tick();
    mem_ack = 1'b0;
    chk("rl_ack_ign_req",   64'(mem_req), 64'(0));
    chk("rl_ack_ign_done",  64'(cnt_done - b_done), 64'(0));
    chk("rl_ack_ign_ready", 64'(instr_ready), 64'(1));
    chk("rl_ack_ign_flat",  64'(regs_flat), 64'(model_flat()));

    // ALU after reset: rd=2 rs1=0 rs2=1, bounded wait for completion
    instr = mk(2'b01, 2'd2, 2'd0, 2'd1, 8'h00, 4'h4); instr_valid = 1'b1; result2 = 8'h5A;
    e1 = m_regs[0]; e2 = m_regs[1];
    model_write(2, 8'h5A); sb_push("alu2");
    tick();
    instr_valid = 1'b0;
    chk("alu2_op1", 64'(operand1), 64'(e1));
    chk("alu2_op2", 64'(operand2), 64'(e2));
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chk("alu2_latency", 64'(lat), 64'(2));
    tick();
    sb_pop();
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Parametrised multi-cycle control unit for the simple CPU: accepts one instruction at a time over a valid/ready handshake, decodes it against an internal NUM_REGS-entry register file, drives ALU and data-memory control, and writes results back. Sits between the instruction source and the ALU/data-memory datapath. Over the previous-generation unit it adds:
- a configurable register count and data width;
- an instruction handshake;
- a data-memory request/acknowledge with wait states;
- store semantics that never write the register file;
- a one-cycle completion pulse.

## Interface
- DATA_WIDTH, 8, datapath/register width
- NUM_REGS, 4, register-file entries; power of two, ≥2; REG_BITS = log2(NUM_REGS)
- INSTR_WIDTH, 2+3*REG_BITS+DATA_WIDTH+4 (20 at defaults), instruction width; derived, not overridden
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge)
- instr  input  INSTR_WIDTH  instruction; fields MSB→LSB: type[2], rd[REG_BITS], rs1[REG_BITS], rs2[REG_BITS], offset[DATA_WIDTH], opcode[4]
- instr_valid  input  1  instr is valid
- instr_ready  output  1  unit can accept an instruction
- result2  input  DATA_WIDTH  ALU result / memory read data for writeback
- mem_ack  input  1  data memory has completed the current request
- operand1  output  DATA_WIDTH  reg[rs1]
- operand2  output  DATA_WIDTH  reg[rs2] (ALU) or reg[rd] (load/store)
- offset  output  DATA_WIDTH  immediate offset field
- opcode  output  4  ALU opcode field
- sel1  output  1  1 = ALU result path, 0 = memory path
- sel3  output  1  1 = offset addressing
- w_r  output  1  memory write strobe
- mem_req  output  1  data-memory request
- done  output  1  one-cycle pulse on instruction completion
- regs_flat  output  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK. Any undefined encoding goes to FETCH.
- FETCH:
  - instr_ready=1.
  - On instr_valid&&instr_ready the instruction is latched internally. Only the latched copy is used afterwards; instr is ignored outside FETCH.
  - type 00 (NOP): accepted and discarded, stays in FETCH, no done pulse.
  - Other types: go to DECODE.
- DECODE → EXECUTE. Drives operand1, operand2, offset, opcode, sel1, sel3 per type:
  - ALU (01): sel1=1, sel3=0.
  - LOAD (10): sel1=0, sel3=1.
  - STORE (11): sel1=0, sel3=1.
- EXECUTE: ALU → WRITEBACK; LOAD/STORE → MEM.
- MEM:
  - mem_req=1; w_r=1 only for STORE.
  - Waits until mem_ack=1.
  - On ack: LOAD → WRITEBACK; STORE → FETCH with done=1.
  - STORE never writes the register file.
- WRITEBACK: reg[rd] <= result2; done=1; → FETCH.
- Datapath outputs hold their last value in all states except where stated.
- Reset values:
  - regfile[i]=i (truncated to DATA_WIDTH).
  - operand1=operand2=offset=0, opcode=4'b1111, sel1=sel3=w_r=mem_req=done=0.
  - State=FETCH, so instr_ready=1 in the first cycle after reset.
- regs_flat is a continuous view of the register file. A write is visible in the cycle after the WRITEBACK edge, with no extra lag.
- Reset mid-instruction: the instruction is abandoned, mem_req/w_r drop on that edge, and the register file is reinitialised.
- mem_ack outside MEM is ignored.

## Timing
- Cycle 0 is the acceptance edge.
- ALU: DECODE c1, EXECUTE c2, WRITEBACK c3 (result2 sampled at the end of c3), FETCH c4. 4 cycles per instruction.
- LOAD: MEM from c3, held for W wait cycles. WRITEBACK at c4+W samples result2. 5+W cycles.
- STORE: MEM from c3. done asserted in the MEM cycle in which mem_ack=1. 4+W cycles.
- mem_req and w_r are registered and asserted from the first MEM cycle. mem_ack may arrive in that same cycle (W=0).
- instr_ready is low in every state except FETCH; back-to-back issue is therefore possible every 4 cycles minimum.

## Configuration
- CU_ZERO_REG_EN defined: register 0 reads as 0, resets to 0, and writes to it are discarded (regs_flat bits [DATA_WIDTH-1:0] are always 0).
- CU_ZERO_REG_EN undefined: register 0 is an ordinary register (reset value 0, writable).

## Test plan
- Reset, then ALU instr type=01 rd=3 rs1=1 rs2=2 opcode=0010, result2=8'h05 during WRITEBACK → operand1=1, operand2=2 from c1; done at c3; regs_flat reg3=8'h05 at c4; instr_ready high at c4.
- LOAD type=10 rd=0 rs1=2 offset=8'h10 with mem_ack delayed 3 cycles, result2=8'hA7 → mem_req high 4 cycles, w_r=0, sel3=1; reg0=8'hA7 after WRITEBACK (8'h00 if CU_ZERO_REG_EN).
- STORE type=11 rd=1 rs1=3 offset=8'h04, mem_ack immediate → w_r=mem_req=1 for exactly 1 cycle, operand2=1, done in the same cycle; regs_flat unchanged.
- NOP stream (type 00) with instr_valid=1 for 5 cycles → instr_ready stays 1, no done, no state change. Changing instr while in DECODE/MEM does not alter outputs.
- rst=0 asserted during a LOAD MEM wait → next cycle mem_req=0, opcode=4'b1111, regs_flat=reset values, instr_ready=1; a later mem_ack is ignored.
